// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access, data first,
// with a bounded number of consecutive data grants while a fetch is waiting.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic         CLK,
  input logic         nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);

  state_t      state;
  logic [2:0]  starve_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_store;
  logic        lat_op;

  logic        data_req;
  logic        i_done;
  logic        d_done;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] store;

  assign data_req = bus.dREN | bus.dWEN;
  assign i_done   = (state == IGRANT) && bus.iREN && (bus.ramstate == RAM_ACCESS);
  assign d_done   = (state == DGRANT) && data_req && (bus.ramstate == RAM_ACCESS);

  // RAM is driven only from latched values, and only while the owner still requests.
  always_comb begin
    ren   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    store = '0;
    case (state)
      IGRANT: begin
        if (bus.iREN) begin
          ren  = 1'b1;
          addr = lat_addr;
        end
      end
      DGRANT: begin
        if (data_req) begin
          ren   = ~lat_op;
          wen   = lat_op;
          addr  = lat_addr;
          store = lat_store;
        end
      end
      default: ;
    endcase
  end

  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.iwait    = bus.iREN & ~i_done;
  assign bus.dwait    = data_req & ~d_done;
  assign bus.iload    = i_done ? bus.ramload : '0;
  assign bus.dload    = (d_done && !lat_op) ? bus.ramload : '0;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_op     <= 1'b0;
    end else begin
      if (!bus.iREN || i_done) begin
        starve_cnt <= '0;
      end else if (d_done && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (data_req && (starve_cnt < LIMIT)) begin
            state     <= DGRANT;
            lat_addr  <= bus.daddr;
            lat_store <= bus.dstore;
            lat_op    <= bus.dWEN;
          end else if (bus.iREN) begin
            state     <= IGRANT;
            lat_addr  <= bus.iaddr;
            lat_store <= '0;
            lat_op    <= 1'b0;
          end
        end
        // A dropped request aborts the grant; ERROR/BUSY/FREE simply hold and retry.
        IGRANT: begin
          if (!bus.iREN || i_done) state <= IDLE;
        end
        DGRANT: begin
          if (!data_req || d_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
  } out_t;

  typedef struct packed {
    logic        active;
    logic        inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
  } grant_t;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;
  out_t exp;

  grant_t g;
  int     starve;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic out_t obs();
    return {bus.iwait, bus.iload, bus.dwait, bus.dload,
            bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore};
  endfunction

  function automatic out_t mk(logic iw, logic [31:0] il, logic dw, logic [31:0] dl,
                              logic ren, logic wen, logic [31:0] a, logic [31:0] st);
    return {iw, il, dw, dl, ren, wen, a, st};
  endfunction

  // Reference: one outstanding grant record; the owner finishes on ACCESS while still asking.
  function automatic out_t model_out();
    out_t e;
    logic ireq, dreq, oreq, done;
    ireq = bus.iREN;
    dreq = bus.dREN | bus.dWEN;
    oreq = g.inst ? ireq : dreq;
    done = g.active && oreq && (bus.ramstate == 2'd2);
    e = '0;
    e.iwait = ireq && !(done && g.inst);
    e.dwait = dreq && !(done && !g.inst);
    if (done && g.inst) e.iload = bus.ramload;
    if (done && !g.inst && !g.wr) e.dload = bus.ramload;
    if (g.active && oreq) begin
      e.ramREN   = g.inst || !g.wr;
      e.ramWEN   = !g.inst && g.wr;
      e.ramaddr  = g.addr;
      e.ramstore = g.inst ? 32'd0 : g.store;
    end
    return e;
  endfunction

  task automatic model_update();
    logic ireq, dreq, oreq, done_i, done_d;
    if (nRST) begin
      g = '0;
      starve = 0;
      return;
    end
    ireq   = bus.iREN;
    dreq   = bus.dREN | bus.dWEN;
    oreq   = g.inst ? ireq : dreq;
    done_i = g.active && oreq && (bus.ramstate == 2'd2) && g.inst;
    done_d = g.active && oreq && (bus.ramstate == 2'd2) && !g.inst;
    if (g.active) begin
      if (!oreq || done_i || done_d) g.active = 1'b0;
    end else if (dreq && starve < LIMIT) begin
      g = {1'b1, 1'b0, bus.dWEN, bus.daddr, bus.dstore};
    end else if (ireq) begin
      g = {1'b1, 1'b1, 1'b0, bus.iaddr, 32'd0};
    end
    if (!ireq || done_i) starve = 0;
    else if (done_d && starve < LIMIT) starve = starve + 1;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic drive(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                       logic [31:0] ds, logic [1:0] rs, logic [31:0] rl);
    bus.iREN     = ir;
    bus.iaddr    = ia;
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
  endtask

  task automatic test_reset();
    g = '0;
    starve = 0;
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    advance();
    @(negedge CLK); exp = mk(0, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL reset_idle: got %h want %h", obs(), exp); end
    drive(1, 32'h44, 1, 0, 32'h88, 0, 2, 32'h1);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK); exp = mk(1, 0, 1, 0, 0, 0, 0, 0); vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL reset_held c%0d: got %h want %h", c, obs(), exp); end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    advance();
  endtask

  task automatic test_fetch_latency();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL latency c0: got %h want %h", obs(), exp); end
    advance();
    for (int c = 1; c <= 2; c++) begin
      drive(1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF);
      @(negedge CLK); exp = mk(1, 0, 0, 0, 1, 0, 32'h40, 0); vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL latency busy c%0d: got %h want %h", c, obs(), exp); end
      advance();
    end
    drive(1, 32'h40, 0, 0, 0, 0, 2, 32'hDEADBEEF);
    @(negedge CLK); exp = mk(0, 32'hDEADBEEF, 0, 0, 1, 0, 32'h40, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL latency done c3: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL latency idle c4: got %h want %h", obs(), exp); end
    advance();
    drive(0, 32'h40, 0, 0, 0, 0, 2, 32'h5);
    @(negedge CLK); exp = mk(0, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL latency abort c5: got %h want %h", obs(), exp); end
    advance();
  endtask

  task automatic test_data_priority();
    drive(1, 32'h80, 0, 1, 32'h100, 32'h1234, 0, 0);
    @(negedge CLK); exp = mk(1, 0, 1, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL priority idle: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h80, 0, 1, 32'h100, 32'h1234, 2, 32'h9999);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 1, 32'h100, 32'h1234); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL priority write: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h80, 0, 0, 0, 0, 2, 32'h7);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL priority gap: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h80, 0, 0, 0, 0, 2, 32'hCAFEF00D);
    @(negedge CLK); exp = mk(0, 32'hCAFEF00D, 0, 0, 1, 0, 32'h80, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL priority fetch: got %h want %h", obs(), exp); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < LIMIT; k++) begin
      drive(1, 32'h200, 1, 0, 32'h300 + k, 0, 0, 0);
      @(negedge CLK); exp = mk(1, 0, 1, 0, 0, 0, 0, 0); vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL starve idle k%0d: got %h want %h", k, obs(), exp); end
      advance();
      drive(1, 32'h200, 1, 0, 32'h3F0, 0, 2, 32'h1000 + k);
      @(negedge CLK); exp = mk(1, 0, 0, 32'h1000 + k, 1, 0, 32'h300 + k, 0); vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL starve data k%0d: got %h want %h", k, obs(), exp); end
      advance();
    end
    drive(1, 32'h200, 1, 0, 32'h3F0, 0, 0, 0);
    advance();
    drive(1, 32'h200, 1, 0, 32'h3F0, 0, 2, 32'h5555);
    @(negedge CLK); exp = mk(0, 32'h5555, 1, 0, 1, 0, 32'h200, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL starve fetch: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h200, 1, 0, 32'h3F0, 0, 0, 0);
    advance();
    @(negedge CLK); exp = mk(1, 0, 1, 0, 1, 0, 32'h3F0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL starve cleared: got %h want %h", obs(), exp); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_error_retry();
    drive(0, 0, 1, 0, 32'h44, 0, 0, 0);
    advance();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 1, 0, 32'h44, 0, 3, 32'h77);
      @(negedge CLK); exp = mk(0, 0, 1, 0, 1, 0, 32'h44, 0); vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL retry err c%0d: got %h want %h", c, obs(), exp); end
      advance();
    end
    drive(0, 0, 1, 0, 32'h44, 0, 2, 32'h99);
    @(negedge CLK); exp = mk(0, 0, 0, 32'h99, 1, 0, 32'h44, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL retry done: got %h want %h", obs(), exp); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_reset_mid_grant();
    drive(1, 32'h60, 0, 0, 0, 0, 1, 0);
    advance();
    advance();
    nRST = 1'b1;
    @(negedge CLK); exp = mk(1, 0, 0, 0, 1, 0, 32'h60, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL rstgrant before: got %h want %h", obs(), exp); end
    advance();
    nRST = 1'b0;
    drive(1, 32'h60, 0, 0, 0, 0, 2, 32'hABCD);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL rstgrant after: got %h want %h", obs(), exp); end
    advance();
    @(negedge CLK); exp = mk(0, 32'hABCD, 0, 0, 1, 0, 32'h60, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL rstgrant regrant: got %h want %h", obs(), exp); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_abort();
    drive(1, 32'h10, 1, 0, 32'h20, 0, 1, 0);
    advance();
    @(negedge CLK); exp = mk(1, 0, 1, 0, 1, 0, 32'h20, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL abort grant: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h10, 0, 0, 32'h20, 0, 2, 32'h31);
    @(negedge CLK); exp = mk(1, 0, 0, 0, 0, 0, 0, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL abort drop: got %h want %h", obs(), exp); end
    advance();
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    advance();
    drive(1, 32'h10, 0, 0, 0, 0, 2, 32'h31);
    @(negedge CLK); exp = mk(0, 32'h31, 0, 0, 1, 0, 32'h10, 0); vectors++;
    if (obs() !== exp) begin miscompares++; $display("FAIL abort fetch: got %h want %h", obs(), exp); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_random();
    logic ir, dr, dw;
    ir = 1'b0;
    dr = 1'b0;
    dw = 1'b0;
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    nRST = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) ir = ~ir;
      if ($urandom_range(0, 3) == 0) dr = ~dr;
      if ($urandom_range(0, 5) == 0) dw = ~dw;
      nRST = ($urandom_range(0, 199) == 0);
      drive(ir, $urandom, dr, dw, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom);
      @(negedge CLK); exp = model_out(); vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL random n%0d: got %h want %h", n, obs(), exp);
      end
      advance();
    end
    nRST = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fetch_latency();
    test_data_priority();
    test_starvation();
    test_error_retry();
    test_reset_mid_grant();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction fetch waits.
REQ-002 CLK  in  1  clock; all state updates on posedge CLK.
REQ-003 nRST  in  1  synchronous, active-high reset; 1 resets on the next posedge CLK.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  fetch address.
REQ-006 iwait  out  1  0 = fetch completes this cycle.
REQ-007 iload  out  32  fetched word, valid while iwait=0.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  write data.
REQ-012 dwait  out  1  0 = data access completes this cycle.
REQ-013 dload  out  32  read word, valid while dwait=0 on a read.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Function
REQ-020 FSM states IDLE, IGRANT, DGRANT; reset state IDLE.
REQ-021 IDLE: ram outputs 0; iwait=1 when iREN=1, dwait=1 when dREN|dWEN=1, else 0.
REQ-022 IDLE -> DGRANT when (dREN|dWEN) and starve_cnt < STARVE_LIMIT.
REQ-023 IDLE -> IGRANT when iREN and (no data request or starve_cnt = STARVE_LIMIT).
REQ-024 On grant, latch address (and dstore, and op type: write if dWEN, else read) into registers; ram outputs driven from latched values only.
REQ-025 dREN and dWEN both 1: treated as a write.
REQ-026 IGRANT: ramREN=1, ramWEN=0, ramaddr=latched iaddr; dwait=1 if data requested.
REQ-027 DGRANT: ramREN=~op, ramWEN=op, ramaddr=latched daddr, ramstore=latched dstore; iwait=1 if iREN.
REQ-028 Completion: in a grant state with ramstate=ACCESS, the owner's wait=0 combinationally that cycle, load=ramload; next state IDLE.
REQ-029 ramstate FREE or BUSY in a grant state: hold state, owner wait=1.
REQ-030 ramstate ERROR: hold state, keep driving request (retry), owner wait=1.
REQ-031 Requester drops its request during its grant state: abort; next state IDLE; no wait=0 pulse; ram outputs 0 in that cycle.
REQ-032 Latency: request seen in IDLE cycle N drives RAM from cycle N+1; completion no earlier than N+1; one IDLE cycle between consecutive grants.
REQ-033 starve_cnt 3-bit: +1 on each data completion with iREN=1; saturates at STARVE_LIMIT; cleared on instruction completion or whenever iREN=0.
REQ-034 iload and dload are 0 whenever their wait is 1 or no request is pending.
REQ-035 ramREN and ramWEN are never 1 together.

Reset
REQ-036 nRST=1 at posedge: state IDLE, starve_cnt 0, latched registers 0; ram outputs 0 from that cycle.
REQ-037 Reset mid-grant abandons the access; no wait=0 pulse is produced for it.
REQ-038 Reset has priority over all transitions.

Verification
REQ-039 iREN=1, iaddr=0x40, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN from cycle 1; iwait=0 with iload=0xDEADBEEF in cycle 3; IDLE in cycle 4.
REQ-040 iREN and dWEN both high in IDLE, daddr=0x100, dstore=0x1234 -> DGRANT first: ramWEN=1, ramstore=0x1234; fetch granted after data completion plus one IDLE cycle.
REQ-041 iREN held, dREN re-asserted after each completion, ACCESS immediately each time -> exactly 4 data grants, then IGRANT; starve_cnt returns to 0.
REQ-042 ramstate=ERROR for 3 cycles then ACCESS in DGRANT read -> ramREN held all 4 cycles; dwait=0 only in the 4th.
REQ-043 nRST=1 in IGRANT cycle 2 -> next cycle ramREN=0, iwait=1 with iREN held; new grant restarts from IDLE.
REQ-044 dREN drops mid-DGRANT -> no dwait=0 pulse, state IDLE next cycle, pending iREN granted after.
